keypad_scanner: RTL and testbench

Scans a 4x4 active-low key matrix by walking one active-low column select at a time, the input-side counterpart of the multiplexed digit driver. It debounces across whole scan frames, rejects multi-key chords, and emits a 4-bit key code with a one-cycle strobe per accepted press. It sits between the board keypad pins and the stopwatch control logic.

---
 rtl/keypad_scanner.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: walks one column at a time, debounces whole
// scan frames, rejects chords and strobes the code of each accepted press.
module keypad_scanner #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] io_row,
  output logic [3:0] io_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [1:0]       acc_n;
  logic [3:0]       acc_key;
  state_t           state, state_d;
  logic [3:0]       cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d, rcnt, rcnt_d;
  logic [3:0]       key_code_d;
  logic             key_valid_d, key_held_d;

  logic             tick_c, frame_end_c, frame_single_c;
  logic [3:0]       hit_c, frame_key_c;
  logic [2:0]       hit_n_c, sum_c;
  logic [1:0]       hit_row_c;

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= io_row;
      row_s2 <= row_s1;
    end
  end

  assign tick_c      = (div == DIV_LAST);
  assign frame_end_c = tick_c && (col_idx == 2'd3);

  // Column dwell divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else if (tick_c) div <= '0;
    else div <= div + DIV_W'(1);
  end

  // Column walker; io_col is registered so it moves the cycle after tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= 2'd0;
      io_col  <= 4'b1110;
    end else if (tick_c) begin
      col_idx <= col_idx + 2'd1;
      io_col  <= ~(4'b0001 << (col_idx + 2'd1));
    end
  end

  // Decode the current column's sample: hit count and lowest hit row.
  always_comb begin
    hit_c     = ~row_s2;
    hit_n_c   = 3'(hit_c[0]) + 3'(hit_c[1]) + 3'(hit_c[2]) + 3'(hit_c[3]);
    hit_row_c = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (hit_c[r]) hit_row_c = 2'(r);
    end
    sum_c          = 3'(acc_n) + hit_n_c;
    frame_single_c = (sum_c == 3'd1);
    frame_key_c    = (acc_n == 2'd1) ? acc_key : {hit_row_c, col_idx};
  end

  // Per-frame accumulation; acc_n saturates at 2 meaning "multiple keys".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n   <= 2'd0;
      acc_key <= 4'd0;
    end else if (frame_end_c) begin
      acc_n   <= 2'd0;
      acc_key <= 4'd0;
    end else if (tick_c) begin
      acc_n <= (sum_c >= 3'd2) ? 2'd2 : 2'(sum_c);
      if (acc_n == 2'd0 && hit_n_c == 3'd1) acc_key <= {hit_row_c, col_idx};
    end
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      cand      <= cand_d;
      cnt       <= cnt_d;
      rcnt      <= rcnt_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end

  // Debounce FSM next-state, evaluated only at frame end.
  always_comb begin
    state_d     = state;
    cand_d      = cand;
    cnt_d       = cnt;
    rcnt_d      = rcnt;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;
    if (frame_end_c) begin
      case (state)
        S_IDLE: begin
          if (frame_single_c) begin
            cand_d  = frame_key_c;
            cnt_d   = CNT_ONE;
            state_d = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (frame_single_c && frame_key_c == cand) begin
            if (cnt >= CNT_LAST) begin
              cnt_d       = CNT_MAX;
              state_d     = S_PRESSED;
              key_code_d  = cand;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt + CNT_ONE;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (!(frame_single_c && frame_key_c == key_code)) begin
            rcnt_d  = CNT_ONE;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (frame_single_c && frame_key_c == key_code) begin
            rcnt_d  = '0;
            state_d = S_PRESSED;
          end else if (rcnt >= CNT_LAST) begin
            rcnt_d     = '0;
            cnt_d      = '0;
            key_held_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            rcnt_d = rcnt + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: keypad matrix model, expected key codes
// queued with stimulus and compared on each key_valid strobe.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] io_row;
  logic [3:0] io_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          exp_q[$];
  int          n_vec;
  int          n_err;
  int          n_pulse;
  int          mon_exp;

  keypad_scanner #(
    .CLK_HZ(16),
    .SCAN_HZ(4),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_row(io_row),
    .io_col(io_col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: row r pulled low while column c is driven and key (r,c) is down.
  always_comb begin
    io_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !io_col[c]) io_row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return at the negedge just after io_col wraps back to column 0.
  task automatic sync_frame();
    logic [3:0] p;
    bit         found;
    found = 1'b0;
    p     = io_col;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (io_col == 4'b1110 && p == 4'b0111) found = 1'b1;
      p = io_col;
    end
    check("frame_sync", int'(found), 1);
  endtask

  // Scoreboard: every strobe must match the oldest queued expected code.
  always @(negedge clk) begin
    if (key_valid) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("key_code_at_valid", int'(key_code), mon_exp);
      end
    end
  end

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    int         p0;
    one     = 4'b0001;
    n_vec   = 0;
    n_err   = 0;
    n_pulse = 0;
    pressed = 16'h0000;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_io_col", int'(io_col), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle column walk.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_col = ~(one << ((i + 1) / 4 % 4));
      check("idle_io_col", int'(io_col), int'(exp_col));
    end
    check("idle_key_held", int'(key_held), 0);
    check("idle_pulses", n_pulse, 0);

    // Clean hold of key (2,1) -> code 9.
    sync_frame();
    p0 = n_pulse;
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_cyc(24);
    check("clean_held_early", int'(key_held), 0);
    wait_cyc(16);
    check("clean_held", int'(key_held), 1);
    check("clean_code", int'(key_code), 9);
    wait_cyc(160);
    check("clean_pulses", n_pulse - p0, 1);
    check("clean_queue", exp_q.size(), 0);
    sync_frame();
    pressed[9] = 1'b0;
    wait_cyc(24);
    check("clean_release_early", int'(key_held), 1);
    wait_cyc(16);
    check("clean_release", int'(key_held), 0);

    // Key (2,1) chattering for 3 frames, then held.
    sync_frame();
    p0 = n_pulse;
    exp_q.push_back(9);
    for (int i = 0; i < 48; i++) begin
      if (i % 5 == 0) pressed[9] = ~pressed[9];
      @(negedge clk);
    end
    pressed[9] = 1'b1;
    wait_cyc(96);
    check("bounce_pulses", n_pulse - p0, 1);
    check("bounce_code", int'(key_code), 9);
    check("bounce_held", int'(key_held), 1);
    check("bounce_queue", exp_q.size(), 0);
    pressed[9] = 1'b0;
    wait_cyc(64);
    check("bounce_release", int'(key_held), 0);

    // Chord (0,0)+(1,1) is rejected.
    sync_frame();
    p0 = n_pulse;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_cyc(128);
    check("chord_pulses", n_pulse - p0, 0);
    check("chord_held", int'(key_held), 0);
    check("chord_code", int'(key_code), 9);
    pressed[0] = 1'b0;
    pressed[5] = 1'b0;
    wait_cyc(32);

    // Release bounce: release 1 frame, re-press 1 frame, release.
    sync_frame();
    p0 = n_pulse;
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_cyc(40);
    check("rb_accept", int'(key_held), 1);
    sync_frame();
    pressed[9] = 1'b0;
    wait_cyc(16);
    check("rb_gap_held", int'(key_held), 1);
    pressed[9] = 1'b1;
    wait_cyc(16);
    check("rb_repress_held", int'(key_held), 1);
    pressed[9] = 1'b0;
    wait_cyc(24);
    check("rb_final_early", int'(key_held), 1);
    wait_cyc(16);
    check("rb_final_release", int'(key_held), 0);
    check("rb_pulses", n_pulse - p0, 1);

    // Reset in the middle of debouncing key (1,1) -> code 5.
    sync_frame();
    pressed[5] = 1'b1;
    wait_cyc(20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_io_col", int'(io_col), 4'b1110);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_held", int'(key_held), 0);
    repeat (3) @(negedge clk);
    p0 = n_pulse;
    rst_n = 1'b1;
    exp_q.push_back(5);
    wait_cyc(24);
    check("post_rst_held_early", int'(key_held), 0);
    check("post_rst_pulses_early", n_pulse - p0, 0);
    wait_cyc(16);
    check("post_rst_held", int'(key_held), 1);
    check("post_rst_code", int'(key_code), 5);
    check("post_rst_queue", exp_q.size(), 0);
    pressed[5] = 1'b0;
    wait_cyc(48);
    check("post_rst_release", int'(key_held), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
